// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: screen mode, lives, BCD score and post-hit invulnerability.
// Optional PAUSE mode is built when GAME_PAUSE_EN is defined.
module game_flow_ctrl #(
  parameter int LIVES_INIT       = 3,
  parameter int SCORE_FRAMES     = 60,
  parameter int INVULN_FRAMES    = 120,
  parameter int OVER_HOLD_FRAMES = 180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic        hit,
  output logic [1:0]  mode,
  output logic [1:0]  lives,
  output logic [15:0] score_bcd,
  output logic        invuln,
  output logic        game_rst
);

  localparam int FRAME_W = (SCORE_FRAMES > 1) ? $clog2(SCORE_FRAMES) : 1;
  localparam int INV_W   = $clog2(INVULN_FRAMES + 1) > 0 ? $clog2(INVULN_FRAMES + 1) : 1;
  localparam int HOLD_W  = $clog2(OVER_HOLD_FRAMES + 1) > 0 ? $clog2(OVER_HOLD_FRAMES + 1) : 1;

  typedef enum logic [1:0] {
    MENU  = 2'b00,
    PLAY  = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          lives_q, lives_d;
  logic [15:0]         score_q, score_d;
  logic                invuln_q, invuln_d;
  logic                game_rst_q, game_rst_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [INV_W-1:0]    inv_q, inv_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                start_prev;
  logic                start_rise;
  logic                pause_rise;

  // Saturating four-digit BCD increment.
  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic        carry;
    r     = s;
    carry = 1'b1;
    if (s != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign start_rise = start_btn & ~start_prev;

`ifdef GAME_PAUSE_EN
  logic pause_prev;
  assign pause_rise = pause_btn & ~pause_prev;
  always_ff @(posedge clk) begin
    if (rst) pause_prev <= 1'b1;
    else     pause_prev <= pause_btn;
  end
`else
  assign pause_rise = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    score_d    = score_q;
    invuln_d   = invuln_q;
    frame_d    = frame_q;
    inv_d      = inv_q;
    hold_d     = hold_q;
    game_rst_d = 1'b0;
    case (state_q)
      MENU: begin
        if (start_rise) begin
          state_d    = PLAY;
          game_rst_d = 1'b1;
          lives_d    = 2'(LIVES_INIT);
          score_d    = 16'h0000;
          frame_d    = '0;
          invuln_d   = 1'b0;
          inv_d      = '0;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          if (frame_q == FRAME_W'(SCORE_FRAMES - 1)) begin
            frame_d = '0;
            score_d = bcd_inc(score_q);
          end else begin
            frame_d = frame_q + 1'b1;
          end
          if (invuln_q) begin
            if (inv_q <= INV_W'(1)) begin
              inv_d    = '0;
              invuln_d = 1'b0;
            end else begin
              inv_d = inv_q - 1'b1;
            end
          end
        end
        // A hit landing on the expiry tick sees invuln_q still set and is dropped.
        if (hit && !invuln_q) begin
          invuln_d = 1'b1;
          inv_d    = INV_W'(INVULN_FRAMES);
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = OVER;
            hold_d  = HOLD_W'(OVER_HOLD_FRAMES);
          end else begin
            lives_d = lives_q - 2'd1;
          end
        end
        if (pause_rise && state_d == PLAY) state_d = PAUSE;
      end
`ifdef GAME_PAUSE_EN
      PAUSE: begin
        if (pause_rise) state_d = PLAY;
      end
`endif
      OVER: begin
        if (frame_tick && hold_q != '0) hold_d = hold_q - 1'b1;
        if (start_rise && hold_q == '0) state_d = MENU;
      end
      default: state_d = MENU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MENU;
      lives_q    <= 2'd0;
      score_q    <= 16'h0000;
      invuln_q   <= 1'b0;
      game_rst_q <= 1'b0;
      frame_q    <= '0;
      inv_q      <= '0;
      hold_q     <= '0;
      start_prev <= 1'b1;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      score_q    <= score_d;
      invuln_q   <= invuln_d;
      game_rst_q <= game_rst_d;
      frame_q    <= frame_d;
      inv_q      <= inv_d;
      hold_q     <= hold_d;
      start_prev <= start_btn;
    end
  end

  assign mode      = state_q;
  assign lives     = lives_q;
  assign score_bcd = score_q;
  assign invuln    = invuln_q;
  assign game_rst  = game_rst_q;

endmodule
